exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; sits directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands and control bits, then generates Val2 (immediate rotate, shift, or memory offset).
- Computes the ALU result and the branch target, and owns the NZCV status register.
- Holds the EXE/MEM pipeline register that feeds the memory stage.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  holds EXE/MEM register and status register (memory-stage stall)
- pc_in  in  32  PC of the instruction (already PC+4)
- mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, imm_in  in  1 each  control from ID/EX
- exec_cmd_in  in  4  ALU command
- val_rn_in, val_rm_in  in  32 each  register operands
- signed_immed_24_in  in  24  branch offset
- shift_operand_in  in  12  ARM shifter operand field
- dest_in  in  4  writeback register index
- branch_addr  out  32  combinational branch target to IF
- status  out  4  NZCV to ID condition check
- alu_res, val_rm  out  32 each  registered, to MEM
- dest  out  4  registered
- mem_r_en, mem_w_en, wb_en  out  1 each  registered

Behaviour:
- Reset: every registered output and status are 0 immediately (async); branch_addr follows its inputs even during reset.
- Val2 priority:
  1. If mem_r_en_in or mem_w_en_in: zero-extended shift_operand[11:0].
  2. Else if imm_in: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  3. Else: val_rm_in shifted by shift_operand[11:7], with shift type [6:5] = 00 LSL, 01 LSR, 10 ASR, 11 ROR. shift_operand[4] is ignored. An amount of 0 means no shift for every type.
- ALU (exec_cmd), carry-in Cin = status C:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+Cin
  - 0100 SUB/CMP: Rn−Val2
  - 0101 SBC: Rn−Val2−~Cin
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code: result 0, and flags are not written.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = carry out of the 33-bit sum (for subtract, C = NOT borrow); V = signed overflow.
  - Logical and move ops: update N and Z only; C and V are retained.
- Status register:
  - Updated on the falling edge of clk when status_w_en_in=1 and freeze=0.
  - This lets the instruction in ID see the new flags within the same cycle.
  - Async reset to 0000.
- branch_addr = pc_in + (sign_extend(signed_immed_24_in) << 2), computed in 32-bit with wrap-around; 0-cycle latency.
- EXE/MEM register:
  - Captures on the rising edge when freeze=0: alu_res, val_rm (= val_rm_in, the unshifted store data), dest, mem_r_en, mem_w_en, wb_en.
  - freeze=1 holds all values.
  - Latency is 1 cycle from ID/EX outputs to the MEM inputs.
- Flush is not handled here; bubbles arrive as all-zero control from ID/EX. A bubble propagates with wb_en=mem_*=0 and does not touch flags.
- Reset asserted mid-stream clears the register and status at once. After release, the first rising edge captures the current inputs.

Decomposition:
- Shared package arm_pkg:
  - exec_cmd encodings (EXE_MOV … EXE_EOR)
  - shift-type constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR)
  - NZCV bit indices
- Sub-module val2_generator: combinational Val2 from imm, mem-op, shift_operand and val_rm.
- ALU and status register stay in exe_stage.

Test Plan:
- ADD overflow: exec=0010, val_rn=0x7FFFFFFF, imm=1, shift_operand=0x001, status_w_en=1 -> after the next edge alu_res=0x80000000; status=1001 after the falling edge.
- CMP equal, then ADC: SUB 5−5 with status_w_en -> status=0110. Next ADC with val_rn=1, Val2=1 -> alu_res=3.
- Immediate rotate and shift:
  - MOV imm=1, shift_operand=0x2FF -> alu_res=0xF000000F.
  - MOV imm=0, shift_operand=0x200, val_rm=1 -> alu_res=0x10.
- Memory and branch:
  - STR: exec=0010, mem_w_en=1, val_rn=0x400, shift_operand=0x010, val_rm=0xABCD -> alu_res=0x410, val_rm=0xABCD, mem_w_en=1.
  - Branch: pc_in=0x100, signed_immed_24=0xFFFFFE -> branch_addr=0xF8 in the same cycle.
- Freeze: hold freeze=1 for 3 cycles while inputs change -> registered outputs and status remain unchanged. Release -> new values appear after 1 edge.
- Reset mid-operation: assert rst between edges while wb_en=1 and status=1001 -> all outputs and status are 0 immediately, without a clock edge.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: ALU command encodings, shifter types,
// NZCV bit positions and the EXE/MEM pipeline register layout.
package arm_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exec_cmd_e;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [WORD_W-1:0] alu_res;
    logic [WORD_W-1:0] val_rm;
    logic [3:0]        dest;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
  } exe_mem_t;

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted Rm.
module val2_generator
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             imm,
  input  logic             mem_op,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] val_rm,
  output logic [WIDTH-1:0] val2
);

  logic [4:0]         rot_amt;
  logic [4:0]         sh_amt;
  logic [WIDTH-1:0]   imm_ext;
  logic [2*WIDTH-1:0] rot_imm_w;
  logic [2*WIDTH-1:0] ror_rm_w;

  always_comb begin
    rot_amt   = {shift_operand[11:8], 1'b0};
    sh_amt    = shift_operand[11:7];
    imm_ext   = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
    // Rotates as a right shift of the doubled word; amount 0 falls out as identity.
    rot_imm_w = {imm_ext, imm_ext} >> rot_amt;
    ror_rm_w  = {val_rm, val_rm} >> sh_amt;
    val2      = '0;
    if (mem_op) begin
      val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    end else if (imm) begin
      val2 = rot_imm_w[WIDTH-1:0];
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << sh_amt;
        SH_LSR:  val2 = val_rm >> sh_amt;
        SH_ASR:  val2 = $signed(val_rm) >>> sh_amt;
        default: val2 = ror_rm_w[WIDTH-1:0];
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: Val2 + ALU, branch target adder, NZCV register
// (falling-edge so ID sees new flags this cycle) and the EXE/MEM register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             status_w_en_in,
  input  logic             imm_in,
  input  logic [3:0]       exec_cmd_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic [23:0]      signed_immed_24_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [3:0]       dest_in,
  output logic [WIDTH-1:0] branch_addr,
  output logic [3:0]       status,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] val_rm,
  output logic [3:0]       dest,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             wb_en
);

  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic             cin_eff;
  logic             arith;
  logic             flag_wr;
  exec_cmd_e        cmd;
  logic [3:0]       status_d, status_q;
  exe_mem_t         exe_mem_d, exe_mem_q;

  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .imm           (imm_in),
    .mem_op        (mem_r_en_in | mem_w_en_in),
    .shift_operand (shift_operand_in),
    .val_rm        (val_rm_in),
    .val2          (val2)
  );

  assign branch_addr = pc_in + {{(WIDTH-26){signed_immed_24_in[23]}}, signed_immed_24_in, 2'b00};

  // Subtracts are Rn + ~Val2 + cin, so C is the inverted borrow for free.
  always_comb begin
    cmd     = exec_cmd_e'(exec_cmd_in);
    opb     = val2;
    cin_eff = 1'b0;
    arith   = 1'b0;
    flag_wr = 1'b1;
    res     = '0;
    case (cmd)
      EXE_MOV: res = val2;
      EXE_MVN: res = ~val2;
      EXE_ADD: arith = 1'b1;
      EXE_ADC: begin arith = 1'b1; cin_eff = status_q[FLAG_C]; end
      EXE_SUB: begin arith = 1'b1; opb = ~val2; cin_eff = 1'b1; end
      EXE_SBC: begin arith = 1'b1; opb = ~val2; cin_eff = status_q[FLAG_C]; end
      EXE_AND: res = val_rn_in & val2;
      EXE_ORR: res = val_rn_in | val2;
      EXE_EOR: res = val_rn_in ^ val2;
      default: flag_wr = 1'b0;
    endcase
    sum = {1'b0, val_rn_in} + {1'b0, opb} + {{WIDTH{1'b0}}, cin_eff};
    if (arith) res = sum[WIDTH-1:0];
  end

  always_comb begin
    status_d = status_q;
    if (status_w_en_in && !freeze && flag_wr) begin
      status_d[FLAG_N] = res[WIDTH-1];
      status_d[FLAG_Z] = (res == '0);
      if (arith) begin
        status_d[FLAG_C] = sum[WIDTH];
        status_d[FLAG_V] = (val_rn_in[WIDTH-1] == opb[WIDTH-1]) &&
                           (res[WIDTH-1] != val_rn_in[WIDTH-1]);
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) status_q <= '0;
    else     status_q <= status_d;
  end

  always_comb begin
    exe_mem_d = exe_mem_q;
    if (!freeze) begin
      exe_mem_d.alu_res  = res;
      exe_mem_d.val_rm   = val_rm_in;
      exe_mem_d.dest     = dest_in;
      exe_mem_d.mem_r_en = mem_r_en_in;
      exe_mem_d.mem_w_en = mem_w_en_in;
      exe_mem_d.wb_en    = wb_en_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exe_mem_q <= '0;
    else     exe_mem_q <= exe_mem_d;
  end

  assign status   = status_q;
  assign alu_res  = exe_mem_q.alu_res;
  assign val_rm   = exe_mem_q.val_rm;
  assign dest     = exe_mem_q.dest;
  assign mem_r_en = exe_mem_q.mem_r_en;
  assign mem_w_en = exe_mem_q.mem_w_en;
  assign wb_en    = exe_mem_q.wb_en;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: driver pushes expected EXE/MEM contents,
// a monitor pops and compares whenever a captured instruction has a live control bit.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [31:0] pc_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, imm_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic [23:0] signed_immed_24_in;
  logic [11:0] shift_operand_in;
  logic [3:0]  dest_in;
  logic [31:0] branch_addr, alu_res, val_rm;
  logic [3:0]  status, dest;
  logic        mem_r_en, mem_w_en, wb_en;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rm;
    logic [3:0]  d;
    logic        mr, mw, wb;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .status_w_en_in(status_w_en_in), .imm_in(imm_in), .exec_cmd_in(exec_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .signed_immed_24_in(signed_immed_24_in),
    .shift_operand_in(shift_operand_in), .dest_in(dest_in), .branch_addr(branch_addr),
    .status(status), .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one instruction 2 time units after a rising edge; it is captured on the next edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] so, input logic im, input logic mr, input logic mw,
                       input logic wb, input logic sw, input logic [3:0] d,
                       input logic [31:0] exp_res, input logic fz);
    exp_t e;
    @(posedge clk); #2;
    exec_cmd_in = cmd; val_rn_in = rn; val_rm_in = rm; shift_operand_in = so;
    imm_in = im; mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb;
    status_w_en_in = sw; dest_in = d; freeze = fz;
    if (!fz && (mr || mw || wb)) begin
      e.res = exp_res; e.rm = rm; e.d = d; e.mr = mr; e.mw = mw; e.wb = wb;
      q.push_back(e);
    end
  endtask

  task automatic chk_status(input string name, input logic [3:0] exp);
    @(negedge clk); #1;
    chk(name, {28'b0, status}, {28'b0, exp});
  endtask

  task automatic chk_branch(input logic [31:0] pc, input logic [23:0] off, input logic [31:0] exp);
    pc_in = pc; signed_immed_24_in = off; #1;
    chk("branch_addr", branch_addr, exp);
  endtask

  // Monitor: freeze/rst sampled at the edge, outputs read 1 unit later.
  always begin
    logic fr, r;
    exp_t e;
    @(posedge clk);
    fr = freeze; r = rst;
    #1;
    if (!r && !rst && !fr && (wb_en || mem_r_en || mem_w_en)) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL exe_mem_unexpected: got alu_res 0x%08h with no pending expectation", alu_res);
      end else begin
        e = q.pop_front();
        chk("exe_mem.alu_res", alu_res, e.res);
        chk("exe_mem.val_rm", val_rm, e.rm);
        chk("exe_mem.ctrl", {25'b0, dest, mem_r_en, mem_w_en, wb_en}, {25'b0, e.d, e.mr, e.mw, e.wb});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; pc_in = '0; signed_immed_24_in = '0;
    mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; status_w_en_in = 0; imm_in = 0;
    exec_cmd_in = '0; val_rn_in = '0; val_rm_in = '0; shift_operand_in = '0; dest_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.alu_res", alu_res, 32'h0);
    chk("reset.status", {28'b0, status}, 32'h0);
    chk("reset.ctrl", {25'b0, dest, mem_r_en, mem_w_en, wb_en}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // cmd, rn, rm, so, imm, mr, mw, wb, sw, dest, expected alu_res, freeze
    issue(4'h2, 32'h7FFFFFFF, 32'h0, 12'h001, 1, 0, 0, 1, 1, 4'd1, 32'h80000000, 0);
    chk_status("status.add_ovf", 4'b1001);
    issue(4'h4, 32'h5, 32'h0, 12'h005, 1, 0, 0, 0, 1, 4'd0, 32'h0, 0);
    chk_status("status.cmp_eq", 4'b0110);
    issue(4'h3, 32'h1, 32'h0, 12'h001, 1, 0, 0, 1, 0, 4'd2, 32'h3, 0);
    issue(4'h1, 32'h0, 32'h0, 12'h2FF, 1, 0, 0, 1, 0, 4'd3, 32'hF000000F, 0);
    issue(4'h1, 32'h0, 32'h1, 12'h200, 0, 0, 0, 1, 0, 4'd4, 32'h10, 0);
    issue(4'h2, 32'h400, 32'hABCD, 12'h010, 0, 0, 1, 0, 0, 4'd0, 32'h410, 0);
    chk_branch(32'h100, 24'hFFFFFE, 32'hF8);
    issue(4'h1, 32'h0, 32'h80000000, 12'h220, 0, 0, 0, 1, 0, 4'd5, 32'h08000000, 0);
    issue(4'h1, 32'h0, 32'h80000000, 12'h240, 0, 0, 0, 1, 0, 4'd6, 32'hF8000000, 0);
    issue(4'h1, 32'h0, 32'h0000000F, 12'h260, 0, 0, 0, 1, 0, 4'd7, 32'hF0000000, 0);
    issue(4'h1, 32'h0, 32'h80000000, 12'h050, 0, 0, 0, 1, 0, 4'd8, 32'h80000000, 0);
    chk_branch(32'h4, 24'hFFFFFE, 32'hFFFFFFFC);
    chk_branch(32'h0, 24'h7FFFFF, 32'h01FFFFFC);
    issue(4'h5, 32'd10, 32'h0, 12'h003, 1, 0, 0, 1, 1, 4'd9, 32'h7, 0);
    chk_status("status.sbc", 4'b0010);
    issue(4'h9, 32'h0, 32'h0, 12'h000, 1, 0, 0, 1, 1, 4'd10, 32'hFFFFFFFF, 0);
    chk_status("status.mvn_keeps_cv", 4'b1010);
    issue(4'h6, 32'hF0F0, 32'h0, 12'h0FF, 1, 0, 0, 1, 0, 4'd11, 32'hF0, 0);
    issue(4'h7, 32'hF00, 32'h0, 12'h0FF, 1, 0, 0, 1, 0, 4'd12, 32'hFFF, 0);
    issue(4'h8, 32'hFF, 32'h0, 12'h0FF, 1, 0, 0, 1, 1, 4'd13, 32'h0, 0);
    chk_status("status.eor_zero", 4'b0110);
    issue(4'hF, 32'h5, 32'h0, 12'h001, 1, 0, 0, 1, 1, 4'd14, 32'h0, 0);
    chk_status("status.bad_cmd_no_write", 4'b0110);
    issue(4'h2, 32'h1000, 32'h77, 12'h2FF, 1, 1, 0, 1, 0, 4'd15, 32'h12FF, 0);

    // Freeze: outputs and flags hold while the inputs keep changing.
    issue(4'h1, 32'h0, 32'h0, 12'h055, 1, 0, 0, 1, 0, 4'd3, 32'h55, 0);
    for (int k = 0; k < 3; k++) begin
      issue(4'h2, 32'h7FFFFFFF, 32'h1 + k, 12'h001, 1, 0, 0, 1, 1, 4'd7, 32'h0, 1);
      chk_status("freeze.status", 4'b0110);
      if (k > 0) begin
        chk("freeze.alu_res", alu_res, 32'h55);
        chk("freeze.dest", {28'b0, dest}, 32'd3);
      end
    end
    issue(4'h1, 32'h0, 32'h0, 12'h0AA, 1, 0, 0, 1, 0, 4'd4, 32'hAA, 0);
    chk("freeze.last_hold", alu_res, 32'h55);

    // Reset mid-stream with wb_en=1 and status=1001.
    issue(4'h2, 32'h7FFFFFFF, 32'h0, 12'h001, 1, 0, 0, 1, 1, 4'd1, 32'h80000000, 0);
    @(posedge clk); #3;
    chk("pre_rst.status", {28'b0, status}, 32'h9);
    chk("pre_rst.wb_en", {31'b0, wb_en}, 32'h1);
    rst = 1'b1; #1;
    chk("rst_async.alu_res", alu_res, 32'h0);
    chk("rst_async.status", {28'b0, status}, 32'h0);
    chk("rst_async.ctrl", {25'b0, dest, mem_r_en, mem_w_en, wb_en}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    q.push_back('{res: 32'h80000000, rm: 32'h0, d: 4'd1, mr: 1'b0, mw: 1'b0, wb: 1'b1});
    chk_status("post_rst.status", 4'b1001);

    // Bubble, drain, and make sure every expectation was consumed.
    issue(4'h0, 32'h0, 32'h0, 12'h000, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
